encoder16to4_seq: RTL and testbench

ENCODER16TO4_SEQ -- requirements
Module: encoder16to4_seq

---
 rtl/encoder16to4_pkg.sv | 13 +
 rtl/lowest_set16.sv | 22 ++
 rtl/encoder16to4_seq.sv | 95 +++++++++
 tb/tb_encoder16to4_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/encoder16to4_pkg.sv
// Shared sizes and FSM state type for the 16-line sequential priority encoder.
package encoder16to4_pkg;

    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;
    localparam int CNT_W   = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

endpackage

// File: rtl/lowest_set16.sv
// Combinational priority pick: index of the lowest set bit plus an any-set flag.
module lowest_set16
    import encoder16to4_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    output logic [CODE_W-1:0]  idx,
    output logic               any
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N_LINES - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = CODE_W'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder16to4_seq.sv
// Sequential 16-to-4 encoder: latches requests into a pending set and serves
// them one code at a time, lowest index first, under a valid/ready handshake.
//
//   state | meaning
//   IDLE  | nothing pending; valid=0, code=0
//   OUT   | code holds a served index; valid=1, waiting for ready
module encoder16to4_seq
    import encoder16to4_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] i,
    input  logic               en,
    input  logic               ready,
    input  logic               clr_ovf,
    output logic               valid,
    output logic [CODE_W-1:0]  code,
    output logic [CNT_W-1:0]   pend_cnt,
    output logic               ovf
);

    state_t              state;
    logic [N_LINES-1:0]  pend;
    logic [N_LINES-1:0]  arrivals;
    logic [N_LINES-1:0]  clr_mask;
    logic [N_LINES-1:0]  p_next;
    logic                accept;
    logic                ovf_hit;
    logic [CNT_W-1:0]    cnt_next;
    logic [CODE_W-1:0]   pick_idx;
    logic                pick_any;

    // An arrival on the line being cleared re-arms it and is not an overflow.
    always_comb begin
        arrivals = en ? i : '0;
        accept   = (state == OUT) && ready;
        clr_mask = accept ? (N_LINES'(1) << code) : '0;
        p_next   = (pend & ~clr_mask) | arrivals;
        ovf_hit  = |(arrivals & pend & ~clr_mask);
        cnt_next = '0;
        for (int k = 0; k < N_LINES; k++) begin
            cnt_next = cnt_next + CNT_W'(p_next[k]);
        end
    end

    lowest_set16 u_pick (
        .req (p_next),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            code     <= '0;
            pend_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            pend     <= p_next;
            pend_cnt <= cnt_next;
            if (ovf_hit) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= OUT;
                        code  <= pick_idx;
                    end
                end
                OUT: begin
                    // Without ready the presented code is frozen, even if a lower line arrives.
                    if (accept) begin
                        if (pick_any) begin
                            code <= pick_idx;
                        end else begin
                            state <= IDLE;
                            code  <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    code  <= '0;
                end
            endcase
        end
    end

    assign valid = (state == OUT);

endmodule

// File: tb/tb_encoder16to4_seq.sv
// Scoreboard bench: a behavioural pending-set model predicts every cycle's outputs.
module tb_encoder16to4_seq;

    typedef struct {
        logic       valid;
        logic [3:0] code;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i = '0;
    logic        en = 1'b0;
    logic        ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        valid;
    logic [3:0]  code;
    logic [4:0]  pend_cnt;
    logic        ovf;

    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    exp_t exp_q[$];

    // Reference model state: the set of outstanding request indices and what is on show.
    bit m_pend[16];
    bit m_valid;
    int m_code;
    bit m_ovf;

    always #5 clk = ~clk;

    encoder16to4_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i        (i),
        .en       (en),
        .ready    (ready),
        .clr_ovf  (clr_ovf),
        .valid    (valid),
        .code     (code),
        .pend_cnt (pend_cnt),
        .ovf      (ovf)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_step(input logic rn, input logic [15:0] ii, input logic e,
                              input logic r, input logic c);
        exp_t x;
        bit   accepted;
        bit   hit;
        int   n;
        if (!rn) begin
            foreach (m_pend[k]) m_pend[k] = 0;
            m_valid = 0;
            m_code  = 0;
            m_ovf   = 0;
        end else begin
            accepted = m_valid && r;
            hit = 0;
            for (int k = 0; k < 16; k++) begin
                bit arrive = e && ii[k];
                bit served = accepted && (k == m_code);
                if (arrive && m_pend[k] && !served) hit = 1;
                m_pend[k] = arrive || (m_pend[k] && !served);
            end
            if (hit) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (!m_valid || accepted) begin
                m_valid = 0;
                m_code  = 0;
                for (int k = 15; k >= 0; k--) begin
                    if (m_pend[k]) begin
                        m_valid = 1;
                        m_code  = k;
                    end
                end
            end
        end
        n = 0;
        foreach (m_pend[k]) n += int'(m_pend[k]);
        x.valid = m_valid;
        x.code  = 4'(m_code);
        x.cnt   = 5'(n);
        x.ovf   = m_ovf;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic rn, input logic [15:0] ii, input logic e,
                       input logic r, input logic c);
        @(negedge clk);
        rst_n   = rn;
        i       = ii;
        en      = e;
        ready   = r;
        clr_ovf = c;
        model_step(rn, ii, e, r, c);
        started = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (started) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 0, 1);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("valid", int'(valid), int'(x.valid));
                check("code", int'(code), int'(x.code));
                check("pend_cnt", int'(pend_cnt), int'(x.cnt));
                check("ovf", int'(ovf), int'(x.ovf));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rv;
        cyc(0, 16'h0000, 0, 0, 0);
        cyc(0, 16'hFFFF, 1, 1, 0);

        // single request, immediate accept
        cyc(1, 16'h0010, 1, 1, 0);
        cyc(1, 16'h0000, 0, 1, 0);
        cyc(1, 16'h0000, 0, 1, 0);

        // two requests with back-pressure
        cyc(1, 16'h8001, 1, 0, 0);
        repeat (3) cyc(1, 16'h0000, 0, 0, 0);
        repeat (3) cyc(1, 16'h0000, 0, 1, 0);

        // all lines at once
        cyc(1, 16'hFFFF, 1, 1, 0);
        repeat (18) cyc(1, 16'h0000, 0, 1, 0);

        // overflow, clear, and re-arm on the accept edge
        cyc(1, 16'h0008, 1, 0, 0);
        cyc(1, 16'h0008, 1, 0, 0);
        cyc(1, 16'h0000, 0, 0, 1);
        cyc(1, 16'h0008, 1, 1, 0);
        repeat (3) cyc(1, 16'h0000, 0, 1, 0);

        // lower index arrives while a code is held
        cyc(1, 16'h0020, 1, 0, 0);
        cyc(1, 16'h0001, 1, 0, 0);
        cyc(1, 16'h0000, 0, 0, 0);
        repeat (3) cyc(1, 16'h0000, 0, 1, 0);

        // reset mid-handshake discards everything
        cyc(1, 16'h00F0, 1, 0, 0);
        cyc(1, 16'h0000, 0, 0, 0);
        cyc(0, 16'h0002, 1, 0, 0);
        repeat (3) cyc(1, 16'h0000, 0, 1, 0);

        // simultaneous overflow set and clear
        cyc(1, 16'h0004, 1, 0, 0);
        cyc(1, 16'h0004, 1, 0, 1);
        cyc(1, 16'h0000, 0, 1, 1);
        cyc(1, 16'h0000, 0, 1, 0);

        for (int n = 0; n < 3000; n++) begin
            rv = 16'($urandom);
            rv = rv & 16'($urandom) & 16'($urandom);
            cyc(($urandom_range(0, 99) != 0), rv, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end
        repeat (20) cyc(1, 16'h0000, 0, 1, 0);

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
